// File: rtl/spi_slave_if.sv
// SPI mode-0 responder: oversamples SCLK/CS_n/MOSI in the clk domain, deserialises MOSI
// into words and serialises a host-supplied word (via a one-entry holding register) onto MISO.
module spi_slave_if #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] settle;
    logic                   sclk_d;
    logic                   cs_d;
    logic                   cs_armed;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_shift_nxt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] tx_shift_nxt;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] hold_nxt;
    logic              hold_full;
    logic              hold_full_nxt;
    logic              word_done;
    logic              word_done_nxt;
    logic [DATA_W-1:0] rx_data_nxt;
    logic              rx_valid_nxt;
    logic              tx_underrun_nxt;
    logic              busy_nxt;
    logic              miso_oe_nxt;
    logic              miso_nxt;
    logic              load;

    // Input synchronisers plus one delayed copy of each control line for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            settle    <= '0;
            cs_armed  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
            settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
            cs_armed  <= cs_armed | (settle[SYNC_STAGES-1] & cs_sync[SYNC_STAGES-1]);
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    // A frame may only start once CS_n has been seen high after reset.
    assign cs_fall   = cs_armed & ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            word_done   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            busy        <= 1'b0;
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b1;
            tx_ready    <= 1'b1;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            rx_shift    <= rx_shift_nxt;
            tx_shift    <= tx_shift_nxt;
            hold        <= hold_nxt;
            hold_full   <= hold_full_nxt;
            word_done   <= word_done_nxt;
            rx_data     <= rx_data_nxt;
            rx_valid    <= rx_valid_nxt;
            tx_underrun <= tx_underrun_nxt;
            busy        <= busy_nxt;
            spi_miso_oe <= miso_oe_nxt;
            spi_miso    <= miso_nxt;
            tx_ready    <= ~hold_full_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bit_cnt_nxt     = bit_cnt;
        rx_shift_nxt    = rx_shift;
        tx_shift_nxt    = tx_shift;
        hold_nxt        = hold;
        hold_full_nxt   = hold_full;
        word_done_nxt   = word_done;
        rx_data_nxt     = rx_data;
        rx_valid_nxt    = 1'b0;
        tx_underrun_nxt = 1'b0;
        load            = 1'b0;

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt     = ACTIVE;
                    bit_cnt_nxt   = '0;
                    rx_shift_nxt  = '0;
                    word_done_nxt = 1'b0;
                    load          = 1'b1;
                end
            end
            ACTIVE: begin
                // Frame end wins over any SCLK edge seen in the same cycle.
                if (cs_rise) begin
                    state_nxt     = IDLE;
                    bit_cnt_nxt   = '0;
                    word_done_nxt = 1'b0;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_nxt = {rx_shift[DATA_W-2:0], mosi_s};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_nxt   = '0;
                            rx_data_nxt   = {rx_shift[DATA_W-2:0], mosi_s};
                            rx_valid_nxt  = 1'b1;
                            word_done_nxt = 1'b1;
                        end else begin
                            bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        end
                    end
                    if (sclk_fall) begin
                        if (word_done) begin
                            load          = 1'b1;
                            word_done_nxt = 1'b0;
                        end else begin
                            tx_shift_nxt = {tx_shift[DATA_W-2:0], 1'b1};
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Word load from the holding register; all ones when nothing is held.
        if (load) begin
            if (hold_full) begin
                tx_shift_nxt  = hold;
                hold_full_nxt = 1'b0;
            end else begin
                tx_shift_nxt    = '1;
                tx_underrun_nxt = 1'b1;
            end
        end

        if (tx_valid && !hold_full) begin
            hold_nxt      = tx_data;
            hold_full_nxt = 1'b1;
        end

        busy_nxt    = (state_nxt == ACTIVE);
        miso_oe_nxt = (state_nxt == ACTIVE);
        miso_nxt    = (state_nxt == ACTIVE) ? tx_shift_nxt[DATA_W-1] : 1'b1;
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised scoreboard bench for spi_slave_if: drives mode-0 frames at clk/8 and checks
// received words, MISO words, underrun pulses and idle/reset output values.
module tb_spi_slave_if;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned HALF        = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int underrun_seen = 0;
    int underrun_exp  = 0;

    logic [DATA_W-1:0] exp_rx[$];
    logic [DATA_W-1:0] hold_q[$];
    logic [DATA_W-1:0] tx_plan[$];
    logic [DATA_W-1:0] mosi_plan[$];

    spi_slave_if #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every rx_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            if (exp_rx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %0h expected no word", rx_data);
            end else begin
                check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
        end
        if (rst_n && tx_underrun) underrun_seen++;
    end

    // Reference model of a word start: take the held word or send all ones.
    function automatic logic [DATA_W-1:0] model_load();
        if (hold_q.size() > 0) return hold_q.pop_front();
        underrun_exp++;
        return '1;
    endfunction

    task automatic do_write(input logic [DATA_W-1:0] val);
        check("tx_ready_before_write", 32'(tx_ready), 32'(hold_q.size() == 0));
        tx_data  = val;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        if (hold_q.size() == 0) hold_q.push_back(val);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_oe"}, 32'(spi_miso_oe), 32'h0);
        check({tag, "_miso"}, 32'(spi_miso), 32'h1);
    endtask

    task automatic send_frame(input int nwords, input int abort_bits, input bit race_write);
        logic [DATA_W-1:0] mw;
        logic [DATA_W-1:0] exp_m;
        logic [DATA_W-1:0] got_m;
        bit done;
        done  = 1'b0;
        exp_m = '0;
        got_m = '0;
        if (!race_write && tx_plan.size() > 0 && hold_q.size() == 0) do_write(tx_plan.pop_front());
        spi_cs_n = 1'b0;
        if (race_write && tx_plan.size() > 0 && hold_q.size() == 0) begin
            // Arrange tx_valid to coincide with the cycle the frame start is detected.
            wait_clk(SYNC_STAGES);
            exp_m = model_load();
            do_write(tx_plan.pop_front());
            wait_clk(6);
        end else begin
            wait_clk(SYNC_STAGES + 6);
            exp_m = model_load();
        end
        check("tx_ready_after_start", 32'(tx_ready), 32'(hold_q.size() == 0));
        check("oe_in_frame", 32'(spi_miso_oe), 32'h1);
        for (int w = 0; w < nwords; w++) begin
            if (!done) begin
                if (w > 0) exp_m = model_load();
                mw = (mosi_plan.size() > 0) ? mosi_plan.pop_front() : DATA_W'($urandom);
                for (int b = 0; b < int'(DATA_W); b++) begin
                    if (!done) begin
                        spi_mosi = mw[DATA_W-1-b];
                        wait_clk(HALF);
                        got_m[DATA_W-1-b] = spi_miso;
                        spi_sclk = 1'b1;
                        if (b == int'(DATA_W) - 1) exp_rx.push_back(mw);
                        if (b == 3 && tx_plan.size() > 0 && hold_q.size() == 0) begin
                            do_write(tx_plan.pop_front());
                            wait_clk(HALF - 1);
                        end else begin
                            wait_clk(HALF);
                        end
                        if ((abort_bits > 0 && w * int'(DATA_W) + b + 1 == abort_bits) ||
                            (w == nwords - 1 && b == int'(DATA_W) - 1)) begin
                            spi_cs_n = 1'b1;
                            wait_clk(2);
                            spi_sclk = 1'b0;
                            done = 1'b1;
                        end else begin
                            spi_sclk = 1'b0;
                        end
                    end
                end
                if (abort_bits == 0 || (w + 1) * int'(DATA_W) <= abort_bits)
                    check("miso_word", 32'(got_m), 32'(exp_m));
            end
        end
        wait_clk(12);
        check_idle("after_frame");
        check("underrun_count", 32'(underrun_seen), 32'(underrun_exp));
        tx_plan.delete();
        mosi_plan.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nw;
        int ab;
        rst_n    = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        wait_clk(3);
        check_idle("reset");
        check("reset_tx_ready", 32'(tx_ready), 32'h1);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_underrun", 32'(tx_underrun), 32'h0);
        rst_n = 1'b1;
        wait_clk(8);

        // Single word with preloaded TX data.
        tx_plan.push_back(8'hA5);
        mosi_plan.push_back(8'h3C);
        send_frame(1, 0, 1'b0);

        // Three back-to-back words with the host refilling mid-word.
        tx_plan = '{8'h11, 8'h22, 8'h33};
        mosi_plan = '{8'hDE, 8'hAD, 8'hBE};
        send_frame(3, 0, 1'b0);

        // Nothing held: all-ones word and an underrun.
        mosi_plan.push_back(8'h00);
        send_frame(1, 0, 1'b0);

        // Aborted frame followed by a full one.
        send_frame(1, 5, 1'b0);
        mosi_plan.push_back(8'h81);
        send_frame(1, 0, 1'b0);

        // Host write racing the frame start with an empty holding register.
        tx_plan.push_back(8'h6B);
        send_frame(2, 0, 1'b1);

        // Reset in the middle of a word, with CS_n still low on release.
        spi_cs_n = 1'b0;
        wait_clk(SYNC_STAGES + 6);
        for (int b = 0; b < 3; b++) begin
            spi_mosi = 1'($urandom);
            wait_clk(HALF);
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
        wait_clk(1);
        rst_n = 1'b0;
        wait_clk(1);
        check_idle("mid_reset");
        check("mid_reset_tx_ready", 32'(tx_ready), 32'h1);
        check("mid_reset_rx_data", 32'(rx_data), 32'h0);
        check("mid_reset_rx_valid", 32'(rx_valid), 32'h0);
        hold_q.delete();
        exp_rx.delete();
        underrun_seen = 0;
        underrun_exp  = 0;
        wait_clk(2);
        rst_n = 1'b1;
        for (int b = 0; b < int'(DATA_W); b++) begin
            spi_mosi = 1'($urandom);
            wait_clk(HALF);
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
        wait_clk(4);
        check_idle("stale_frame");
        spi_cs_n = 1'b1;
        wait_clk(8);
        mosi_plan.push_back(8'h5A);
        send_frame(1, 0, 1'b0);

        // Randomised frames.
        for (int f = 0; f < 10; f++) begin
            nw = int'($urandom_range(1, 3));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nw * int'(DATA_W) - 1)) : 0;
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) tx_plan.push_back(DATA_W'($urandom));
            send_frame(nw, ab, 1'($urandom_range(0, 1)));
        end

        wait_clk(10);
        check("rx_queue_drained", 32'(exp_rx.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
